// File: rtl/nv_nvdla_reset_seq.sv
// -----------------------------------------------------------------------------
// nv_nvdla_reset_seq
//
// Reset sequencer for the NVDLA core reset synchronizer. On power-on and on
// every software reset request it drives dla_reset_rstn low for HOLD_CYCLES
// cycles and then releases it. It then waits for the synchronizer feedback
// (synced_rstn) to release and completes the request with a 4-phase
// sw_rst_req/sw_rst_ack handshake. If the feedback never releases within
// TIMEOUT_CYCLES, a sticky rst_timeout flag is set and the sequence ends
// anyway.
//
// Handshake: sw_rst_req is a level. A request is accepted only in IDLE while
// sw_rst_ack is low. sw_rst_ack rises once the sequence completes and stays
// high until sw_rst_req drops; it falls on the edge after sw_rst_req is seen
// low. A request withdrawn before completion does not abort the sequence and
// produces no ack.
//
// Ports:
//   nvdla_clk        in   core clock (single clock domain)
//   core_reset_rstn  in   asynchronous active-low block reset
//   sw_rst_req       in   software reset request (level, 4-phase)
//   sw_rst_ack       out  request-complete acknowledge
//   dla_reset_rstn   out  registered active-low reset to the synchronizer
//   synced_rstn      in   synchronizer output feedback (asynchronous)
//   rst_busy         out  high whenever the sequencer is not IDLE
//   rst_timeout      out  sticky release-wait timeout flag
//   timeout_clr      in   single-cycle clear of rst_timeout
//   dbg_state        out  current FSM state (HOLD=0, WAIT_REL=1, IDLE=2, ACK=3)
// -----------------------------------------------------------------------------
module nv_nvdla_reset_seq #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       nvdla_clk,
    input  logic       core_reset_rstn,
    input  logic       sw_rst_req,
    output logic       sw_rst_ack,
    output logic       dla_reset_rstn,
    input  logic       synced_rstn,
    output logic       rst_busy,
    output logic       rst_timeout,
    input  logic       timeout_clr,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_REL = 2'd1,
        ST_IDLE     = 2'd2,
        ST_ACK      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              pend_q,    pend_d;
    logic [1:0]        fb_sync_q;
    logic              dla_q,     dla_d;
    logic              ack_q,     ack_d;
    logic              busy_q,    busy_d;
    logic              timeout_q, timeout_d;

    // Feedback synchronizer: synced_rstn can release at any time relative
    // to nvdla_clk, so only fb_sync_q[1] is used by the FSM.
    always_ff @(posedge nvdla_clk or negedge core_reset_rstn) begin
        if (!core_reset_rstn) begin
            fb_sync_q <= 2'b00;
        end else begin
            fb_sync_q <= {fb_sync_q[0], synced_rstn};
        end
    end

    always_ff @(posedge nvdla_clk or negedge core_reset_rstn) begin
        if (!core_reset_rstn) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            dla_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            dla_q     <= dla_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        dla_d     = dla_q;
        ack_d     = ack_q;
        timeout_d = timeout_q;

        // A timeout set below overrides a coincident clear.
        if (timeout_clr) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            ST_HOLD: begin
                dla_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_REL;
                    dla_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_REL: begin
                dla_d = 1'b1;
                if (fb_sync_q[1] || (cnt_q == TIMEOUT_LAST)) begin
                    // Release is checked first so it wins over a same-cycle
                    // timeout.
                    if (!fb_sync_q[1]) begin
                        timeout_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (pend_q) begin
                        state_d = ST_ACK;
                        // A request already withdrawn gets no ack pulse.
                        ack_d   = sw_rst_req;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                // Loss of synced_rstn here is an external reset; ignored.
                if (sw_rst_req && !ack_q) begin
                    pend_d  = 1'b1;
                    state_d = ST_HOLD;
                    dla_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            ST_ACK: begin
                if (!sw_rst_req) begin
                    ack_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                dla_d   = 1'b0;
                ack_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign sw_rst_ack     = ack_q;
    assign dla_reset_rstn = dla_q;
    assign rst_busy       = busy_q;
    assign rst_timeout    = timeout_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_nv_nvdla_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_nv_nvdla_reset_seq
//
// Directed bench for nv_nvdla_reset_seq with HOLD_CYCLES=16 and
// TIMEOUT_CYCLES=255. synced_rstn is dla_reset_rstn passed through two
// bench flops (a 2-cycle loopback) unless fb_stuck forces it to 0.
//
// Loopback timing from the release edge R of dla_reset_rstn:
//   R+1 first loopback flop, R+2 synced_rstn high, R+3 fb_sync[0],
//   R+4 fb_sync[1], R+5 FSM leaves WAIT_REL (busy falls / ack rises).
// -----------------------------------------------------------------------------
module tb_nv_nvdla_reset_seq;

    localparam int HOLD    = 16;
    localparam int TIMEOUT = 255;
    localparam int LOOP_LAT = 5;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_IDLE = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       timeout_clr = 1'b0;
    logic       fb_stuck = 1'b0;
    logic       loop_d1 = 1'b0;
    logic       loop_d2 = 1'b0;
    logic       synced_rstn;
    logic       sw_rst_ack;
    logic       dla_reset_rstn;
    logic       rst_busy;
    logic       rst_timeout;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        loop_d1 <= dla_reset_rstn;
        loop_d2 <= loop_d1;
    end
    assign synced_rstn = fb_stuck ? 1'b0 : loop_d2;

    nv_nvdla_reset_seq #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (8)
    ) dut (
        .nvdla_clk      (clk),
        .core_reset_rstn(rst_n),
        .sw_rst_req     (sw_rst_req),
        .sw_rst_ack     (sw_rst_ack),
        .dla_reset_rstn (dla_reset_rstn),
        .synced_rstn    (synced_rstn),
        .rst_busy       (rst_busy),
        .rst_timeout    (rst_timeout),
        .timeout_clr    (timeout_clr),
        .dbg_state      (dbg_state)
    );

    // ---------------- ack pulse counter ----------------
    int   ack_rises = 0;
    logic ack_prev  = 1'b0;
    always @(negedge clk) begin
        if (sw_rst_ack && !ack_prev) ack_rises++;
        ack_prev = sw_rst_ack;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // which: 0 dla_reset_rstn, 1 rst_busy, 2 sw_rst_ack, 3 rst_timeout
    function automatic logic get_sig(input int which);
        case (which)
            0:       return dla_reset_rstn;
            1:       return rst_busy;
            2:       return sw_rst_ack;
            default: return rst_timeout;
        endcase
    endfunction

    // Counts edges until the chosen signal reads v; bounded by limit.
    task automatic edges_until(input int which, input logic v, input int limit,
                               output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (get_sig(which) !== v && n < limit);
    endtask

    int n;
    int ack_base;
    int hold_len;

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // ---------- power-on ----------
        #12;
        check_val("rst_dla",     dla_reset_rstn, 0);
        check_val("rst_ack",     sw_rst_ack,     0);
        check_val("rst_busy",    rst_busy,       1);
        check_val("rst_timeout", rst_timeout,    0);
        check_val("rst_state",   dbg_state,      S_HOLD);
        release_reset();
        edges_until(0, 1'b1, 100, n);
        check_val("por_hold_edges", n, HOLD);
        check_val("por_state_wait", dbg_state, S_WAIT);
        edges_until(1, 1'b0, 50, n);
        check_val("por_busy_fall", n, LOOP_LAT);
        check_val("por_state_idle", dbg_state, S_IDLE);
        check_val("por_ack", sw_rst_ack, 0);
        check_val("por_timeout", rst_timeout, 0);

        // ---------- software reset in IDLE ----------
        ack_base = ack_rises;
        sw_rst_req = 1'b1;
        tick();
        check_val("sw_dla_fall", dla_reset_rstn, 0);
        check_val("sw_busy", rst_busy, 1);
        edges_until(0, 1'b1, 100, n);
        check_val("sw_hold_edges", n, HOLD);
        edges_until(2, 1'b1, 50, n);
        check_val("sw_ack_lat", n, LOOP_LAT);
        for (int i = 0; i < 3; i++) tick();
        check_val("sw_ack_held", sw_rst_ack, 1);
        check_val("sw_state_ack", dbg_state, S_ACK);
        sw_rst_req = 1'b0;
        tick();
        check_val("sw_ack_fall", sw_rst_ack, 0);
        check_val("sw_busy_idle", rst_busy, 0);
        check_val("sw_ack_pulses", ack_rises - ack_base, 1);

        // ---------- request held during power-on ----------
        #2 rst_n = 1'b0;
        sw_rst_req = 1'b1;
        ack_base = ack_rises;
        release_reset();
        edges_until(0, 1'b1, 100, n);
        check_val("hpo_hold_edges", n, HOLD);
        check_val("hpo_no_early_ack", sw_rst_ack, 0);
        edges_until(1, 1'b0, 50, n);
        check_val("hpo_busy_fall", n, LOOP_LAT);
        check_val("hpo_idle", dbg_state, S_IDLE);
        tick();
        check_val("hpo_restart_dla", dla_reset_rstn, 0);
        check_val("hpo_restart_busy", rst_busy, 1);
        edges_until(0, 1'b1, 100, n);
        check_val("hpo_hold2_edges", n, HOLD);
        edges_until(2, 1'b1, 50, n);
        check_val("hpo_ack_lat", n, LOOP_LAT);
        sw_rst_req = 1'b0;
        tick();
        check_val("hpo_ack_fall", sw_rst_ack, 0);
        check_val("hpo_ack_pulses", ack_rises - ack_base, 1);

        // ---------- core reset at cnt=7 of a software sequence ----------
        sw_rst_req = 1'b1;
        tick();                              // enters HOLD, cnt=0
        for (int i = 0; i < 7; i++) tick();  // cnt=7
        check_val("mid_state_hold", dbg_state, S_HOLD);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_dla", dla_reset_rstn, 0);
        check_val("mid_rst_ack", sw_rst_ack, 0);
        check_val("mid_rst_state", dbg_state, S_HOLD);
        release_reset();
        edges_until(0, 1'b1, 100, n);
        check_val("mid_por_hold", n, HOLD);
        edges_until(1, 1'b0, 50, n);
        check_val("mid_por_busy_fall", n, LOOP_LAT);
        tick();
        check_val("mid_serve_dla", dla_reset_rstn, 0);
        edges_until(0, 1'b1, 100, n);
        check_val("mid_serve_hold", n, HOLD);
        edges_until(2, 1'b1, 50, n);
        check_val("mid_serve_ack", n, LOOP_LAT);

        // ---------- core reset while acknowledging ----------
        #1 rst_n = 1'b0;
        #1;
        check_val("ack_rst_dla", dla_reset_rstn, 0);
        check_val("ack_rst_ack", sw_rst_ack, 0);
        check_val("ack_rst_busy", rst_busy, 1);
        sw_rst_req = 1'b0;
        release_reset();
        edges_until(0, 1'b1, 100, n);
        check_val("ack_rst_por_hold", n, HOLD);
        edges_until(1, 1'b0, 50, n);
        check_val("ack_rst_por_busy", n, LOOP_LAT);
        check_val("ack_rst_por_ack", sw_rst_ack, 0);

        // ---------- request withdrawn in HOLD ----------
        ack_base = ack_rises;
        sw_rst_req = 1'b1;
        tick();
        hold_len = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            hold_len++;
        end
        sw_rst_req = 1'b0;
        edges_until(0, 1'b1, 100, n);
        // hold_len counts edges with dla low, excluding the release edge.
        hold_len = hold_len - 1 + n;
        check_val("wd_hold_len", hold_len, HOLD);
        // Exits WAIT_REL into ACK, then ACK sees no request one edge later.
        edges_until(1, 1'b0, 50, n);
        check_val("wd_busy_fall", n, LOOP_LAT + 1);
        check_val("wd_no_ack", ack_rises - ack_base, 0);

        // ---------- timeout on power-on ----------
        #2 rst_n = 1'b0;
        fb_stuck = 1'b1;
        release_reset();
        edges_until(0, 1'b1, 100, n);
        check_val("to_hold", n, HOLD);
        edges_until(3, 1'b1, 400, n);
        check_val("to_edges", n, TIMEOUT);
        check_val("to_state_idle", dbg_state, S_IDLE);
        check_val("to_busy", rst_busy, 0);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        check_val("to_clear", rst_timeout, 0);

        // ---------- release on the timeout cycle: release wins ----------
        sw_rst_req = 1'b1;
        tick();
        edges_until(0, 1'b1, 100, n);
        check_val("rw_hold", n, HOLD);
        for (int i = 0; i < 252; i++) tick();
        fb_stuck = 1'b0;
        tick();
        tick();
        check_val("rw_still_wait", dbg_state, S_WAIT);
        tick();
        check_val("rw_ack", sw_rst_ack, 1);
        check_val("rw_no_timeout", rst_timeout, 0);
        sw_rst_req = 1'b0;
        tick();
        check_val("rw_ack_fall", sw_rst_ack, 0);

        // ---------- clear coincident with new timeout: set wins ----------
        fb_stuck = 1'b1;
        sw_rst_req = 1'b1;
        tick();
        edges_until(0, 1'b1, 100, n);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_val("cc_before", rst_timeout, 0);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        check_val("cc_set_wins", rst_timeout, 1);
        check_val("cc_state_ack", dbg_state, S_ACK);
        check_val("cc_ack", sw_rst_ack, 1);
        sw_rst_req = 1'b0;
        tick();
        check_val("cc_ack_fall", sw_rst_ack, 0);
        check_val("cc_sticky", rst_timeout, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
